// File: rtl/controller_pkg.sv
// ---------------------------------------------------------------------------
// controller_pkg
// Shared types and constants for the serial game-controller poller.
//   state_t          : scan sequencer states
//   BTN_*            : bit positions of each button inside a controller byte
//   LATCH_TICKS      : number of ticks the latch strobe is held high
//   BITS_PER_CTRL    : serial bits read from each controller per scan
//   shift_in()       : MSB-first shift helper for the per-controller buffers
// ---------------------------------------------------------------------------
package controller_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LATCH = 3'd1,
      LOW   = 3'd2,
      HIGH  = 3'd3,
      DONE  = 3'd4
   } state_t;

   localparam int BTN_A      = 7;
   localparam int BTN_B      = 6;
   localparam int BTN_SELECT = 5;
   localparam int BTN_START  = 4;
   localparam int BTN_UP     = 3;
   localparam int BTN_DOWN   = 2;
   localparam int BTN_LEFT   = 1;
   localparam int BTN_RIGHT  = 0;

   localparam int LATCH_TICKS   = 2;
   localparam int BITS_PER_CTRL = 8;

   // First bit shifted in ends up at the MSB (button A) after a full byte.
   function automatic logic [BITS_PER_CTRL-1:0] shift_in(
      input logic [BITS_PER_CTRL-1:0] cur,
      input logic                     bit_v
   );
      return {cur[BITS_PER_CTRL-2:0], bit_v};
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a bus of independent asynchronous bits.
// Ports:
//   clk   : destination clock
//   rst_n : asynchronous active-low reset
//   d     : asynchronous input bits
//   q     : synchronized bits, two clk cycles of latency
// Resets to all-ones, the idle (released / disconnected) level of the
// controller data lines.
// ---------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_r;
   logic [WIDTH-1:0] sync_r;

   // Metastability filter: two back-to-back capture stages.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_r <= '1;
         sync_r <= '1;
      end else begin
         meta_r <= d;
         sync_r <= meta_r;
      end
   end

   assign q = sync_r;

endmodule

// File: rtl/controller_reader.sv
// ---------------------------------------------------------------------------
// controller_reader
// Console-side poller for serial game controllers. On a scan request it
// strobes the shared latch, clocks eight bits out of every controller and
// publishes one active-high button byte per controller.
// Ports:
//   clk           : system clock
//   rst_n         : asynchronous active-low reset (aborts any scan)
//   start         : scan request, honoured only while idle
//   busy          : scan in progress
//   latch         : parallel-load strobe to the controllers
//   ctrl_clk      : serial shift clock, controllers shift on its rising edge
//   data_B        : per-controller serial data, active low, asynchronous
//   buttons       : byte n = controller n, {a,b,select,start,up,down,left,right}
//   buttons_valid : one-cycle pulse when buttons is updated
// All outputs come straight from flops. They are loaded from the next-state
// value so that they change on the same edge as the state they belong to.
// ---------------------------------------------------------------------------
module controller_reader
   import controller_pkg::*;
#(
   parameter int CLK_DIV  = 4,
   parameter int NUM_CTRL = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   output logic                  busy,
   output logic                  latch,
   output logic                  ctrl_clk,
   input  logic [NUM_CTRL-1:0]   data_B,
   output logic [8*NUM_CTRL-1:0] buttons,
   output logic                  buttons_valid
);

   localparam int               DIV_W      = 16;
   localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
   localparam logic [1:0]       LATCH_LAST = 2'(LATCH_TICKS - 1);
   localparam logic [2:0]       BIT_LAST   = 3'(BITS_PER_CTRL - 1);

   state_t                state_r;
   state_t                state_nx_s;
   logic [DIV_W-1:0]      div_r;
   logic                  tick_s;
   logic [1:0]            latch_cnt_r;
   logic [2:0]            bit_idx_r;
   logic [NUM_CTRL-1:0]   data_sync_s;
   logic [8*NUM_CTRL-1:0] shreg_r;
   logic [8*NUM_CTRL-1:0] buttons_r;
   logic                  latch_r;
   logic                  ctrl_clk_r;
   logic                  busy_r;
   logic                  valid_r;

   sync_2ff #(
      .WIDTH (NUM_CTRL)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (data_B),
      .q     (data_sync_s)
   );

   assign tick_s = (div_r == DIV_LAST);

   // Next-state logic; every phase other than IDLE/DONE advances on a tick.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = LATCH;
            end else begin
               state_nx_s = IDLE;
            end
         end
         LATCH: begin
            if (tick_s && (latch_cnt_r == LATCH_LAST)) begin
               state_nx_s = LOW;
            end else begin
               state_nx_s = LATCH;
            end
         end
         LOW: begin
            if (tick_s) begin
               state_nx_s = HIGH;
            end else begin
               state_nx_s = LOW;
            end
         end
         HIGH: begin
            if (tick_s) begin
               if (bit_idx_r == BIT_LAST) begin
                  state_nx_s = DONE;
               end else begin
                  state_nx_s = LOW;
               end
            end else begin
               state_nx_s = HIGH;
            end
         end
         DONE: begin
            state_nx_s = IDLE;
         end
         default: begin
            state_nx_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Tick divider; held at zero in IDLE so every scan starts on phase 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_r <= '0;
      end else if ((state_r == IDLE) || tick_s) begin
         div_r <= '0;
      end else begin
         div_r <= div_r + 16'd1;
      end
   end

   // Counts latch ticks; cleared whenever the sequencer is outside LATCH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_cnt_r <= 2'd0;
      end else if (state_r != LATCH) begin
         latch_cnt_r <= 2'd0;
      end else if (tick_s) begin
         latch_cnt_r <= latch_cnt_r + 2'd1;
      end else begin
         latch_cnt_r <= latch_cnt_r;
      end
   end

   // Bit index advances at the end of each HIGH phase and stops at the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_idx_r <= 3'd0;
      end else if (state_r == IDLE) begin
         bit_idx_r <= 3'd0;
      end else if ((state_r == HIGH) && tick_s && (bit_idx_r != BIT_LAST)) begin
         bit_idx_r <= bit_idx_r + 3'd1;
      end else begin
         bit_idx_r <= bit_idx_r;
      end
   end

   // Sample at the end of LOW, when the data line has been stable a full tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg_r <= '0;
      end else if ((state_r == LOW) && tick_s) begin
         for (int n = 0; n < NUM_CTRL; n++) begin
            shreg_r[8*n +: 8] <= shift_in(shreg_r[8*n +: 8], ~data_sync_s[n]);
         end
      end else begin
         shreg_r <= shreg_r;
      end
   end

   // Output flops, loaded from the next state; buttons only move on DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_r    <= 1'b0;
         ctrl_clk_r <= 1'b0;
         busy_r     <= 1'b0;
         valid_r    <= 1'b0;
         buttons_r  <= '0;
      end else begin
         latch_r    <= (state_nx_s == LATCH);
         ctrl_clk_r <= (state_nx_s == HIGH);
         busy_r     <= (state_nx_s != IDLE);
         valid_r    <= (state_nx_s == DONE);
         if (state_nx_s == DONE) begin
            buttons_r <= shreg_r;
         end else begin
            buttons_r <= buttons_r;
         end
      end
   end

   assign latch         = latch_r;
   assign ctrl_clk      = ctrl_clk_r;
   assign busy          = busy_r;
   assign buttons_valid = valid_r;
   assign buttons       = buttons_r;

endmodule

// File: tb/tb_controller_reader.sv
// ---------------------------------------------------------------------------
// tb_controller_reader
// Scoreboard bench: stimulus pushes the expected button word (derived from
// the modelled controllers' pad state) into a queue; a monitor thread pops
// and compares on every buttons_valid and also checks scan timing.
// dut_a runs CLK_DIV=4, dut_b runs CLK_DIV=7 with its data lines tied high.
// ---------------------------------------------------------------------------
module tb_controller_reader;

   localparam int CD_A = 4;
   localparam int CD_B = 7;
   localparam int NC   = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;

   logic            start_a, busy_a, latch_a, cclk_a, valid_a;
   logic [NC-1:0]   data_a;
   logic [8*NC-1:0] btn_a;

   logic            start_b, busy_b, latch_b, cclk_b, valid_b;
   logic [NC-1:0]   data_b;
   logic [8*NC-1:0] btn_b;

   controller_reader #(.CLK_DIV(CD_A), .NUM_CTRL(NC)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a),
      .latch(latch_a), .ctrl_clk(cclk_a), .data_B(data_a),
      .buttons(btn_a), .buttons_valid(valid_a)
   );

   controller_reader #(.CLK_DIV(CD_B), .NUM_CTRL(NC)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b),
      .latch(latch_b), .ctrl_clk(cclk_b), .data_B(data_b),
      .buttons(btn_b), .buttons_valid(valid_b)
   );

   // ---------------- controller model (active-low pads, shift register) ----
   logic [7:0] pad_b [NC];
   logic [7:0] sr    [NC] = '{default: 8'hFF};
   logic       cclk_prev = 1'b0;

   always @(negedge clk) begin
      for (int n = 0; n < NC; n++) begin
         if (latch_a)
            sr[n] <= pad_b[n];
         else if (cclk_a && !cclk_prev)
            sr[n] <= {sr[n][6:0], 1'b1};
      end
      cclk_prev <= cclk_a;
   end

   always_comb begin
      data_a = '0;
      for (int n = 0; n < NC; n++) data_a[n] = sr[n][7];
   end

   // Reference: each controller's byte is simply the inverse of its pad state.
   function automatic logic [8*NC-1:0] ref_buttons(input logic [7:0] p [NC]);
      logic [8*NC-1:0] r;
      r = '0;
      for (int n = 0; n < NC; n++) r[8*n +: 8] = ~p[n];
      return r;
   endfunction

   // ---------------- bookkeeping ------------------------------------------
   int n_pass   = 0;
   int n_checks = 0;
   int cyc      = 0;
   int valid_cnt = 0;
   int held_seen = 0;
   logic held = 1'b0;
   logic [8*NC-1:0] exp_q [$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, required %0h (cycle %0d)", nm, act, req, cyc);
   endtask

   // Monitor: pops the scoreboard on every valid and checks scan timing.
   task automatic monitor();
      int lat_w = 0, edges = 0, rise_cyc = 0, last_valid = 0;
      logic lp = 1'b0, cp = 1'b0, bchk = 1'b0;
      logic [8*NC-1:0] last_btn = '0;
      logic [8*NC-1:0] e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            lat_w = 0; edges = 0; lp = 1'b0; cp = 1'b0; bchk = 1'b0; last_btn = '0;
         end else begin
            if (bchk) begin
               check("busy_after_valid", 32'(busy_a), 32'd0);
               bchk = 1'b0;
            end
            if (latch_a && !lp) begin rise_cyc = cyc; lat_w = 0; edges = 0; end
            if (latch_a) lat_w++;
            if (cclk_a && !cp) edges++;
            if (valid_a) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_valid", 32'(valid_a), 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  check("buttons", 32'(btn_a), 32'(e));
               end
               check("latch_width", lat_w, 2*CD_A);
               check("ctrl_clk_edges", edges, 8);
               check("valid_latency", cyc - rise_cyc, 18*CD_A);
               if (held) begin
                  if (held_seen > 0) check("valid_spacing", cyc - last_valid, 18*CD_A + 2);
                  held_seen++;
               end else begin
                  held_seen = 0;
               end
               last_valid = cyc;
               last_btn   = btn_a;
               valid_cnt++;
               bchk = 1'b1;
            end else if (btn_a !== last_btn) begin
               check("buttons_hold", 32'(btn_a), 32'(last_btn));
               last_btn = btn_a;
            end
            lp = latch_a;
            cp = cclk_a;
         end
      end
   endtask

   task automatic pulse_start();
      start_a = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
   endtask

   task automatic wait_valid(input int target, input int budget);
      int c = 0;
      while (valid_cnt < target && c < budget) begin
         @(posedge clk); #2;
         c++;
      end
      if (valid_cnt < target) check("valid_timeout", valid_cnt, target);
   endtask

   task automatic rand_pads();
      for (int n = 0; n < NC; n++) pad_b[n] = 8'($urandom_range(255, 0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
      $fatal(1);
   end

   // ---------------- stimulus ----------------------------------------------
   initial begin
      int tgt, k, lw, r1, r2, vb, bval;
      logic pc;
      logic [7:0] ones [NC];

      rst_n = 1'b0; start_a = 1'b0; start_b = 1'b0; data_b = '1;
      pad_b = '{default: 8'hFF};
      fork monitor(); join_none

      repeat (3) @(posedge clk);
      #1;
      check("rst_latch",    32'(latch_a), 32'd0);
      check("rst_ctrl_clk", 32'(cclk_a),  32'd0);
      check("rst_busy",     32'(busy_a),  32'd0);
      check("rst_buttons",  32'(btn_a),   32'd0);
      check("rst_valid",    32'(valid_a), 32'd0);
      check("rst_busy_b",   32'(busy_b),  32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // basic scan
      pad_b[0] = 8'b0111_1110; pad_b[1] = 8'hFF;
      exp_q.push_back(ref_buttons(pad_b));
      tgt = valid_cnt + 1;
      pulse_start();
      wait_valid(tgt, 200);

      // pads change after latch falls; extra start at cycle 20 is ignored
      @(posedge clk); #1;
      pad_b[0] = 8'h00; pad_b[1] = 8'h55;
      exp_q.push_back(ref_buttons(pad_b));
      tgt = valid_cnt + 1;
      pulse_start();
      repeat (11) begin @(posedge clk); #1; end
      rand_pads();
      repeat (7) begin @(posedge clk); #1; end
      pulse_start();
      wait_valid(tgt, 200);
      repeat (90) @(posedge clk);
      #1;
      check("ignored_start", valid_cnt, tgt);

      // random scans with a stray start somewhere in 1..73 cycles of the scan
      for (int it = 0; it < 12; it++) begin
         rand_pads();
         exp_q.push_back(ref_buttons(pad_b));
         tgt = valid_cnt + 1;
         k = (it == 0) ? 73 : $urandom_range(73, 1);
         pulse_start();
         repeat (k - 1) begin @(posedge clk); #1; end
         pulse_start();
         wait_valid(tgt, 200);
         repeat ($urandom_range(4, 1)) @(posedge clk);
         #1;
      end
      repeat (80) @(posedge clk);
      #1;

      // start held high for three back-to-back scans
      held = 1'b1;
      rand_pads(); pad_b[0] = 8'hFE;
      exp_q.push_back(ref_buttons(pad_b));
      tgt = valid_cnt + 1;
      start_a = 1'b1;
      wait_valid(tgt, 200);
      rand_pads(); pad_b[0] = 8'hFD;
      exp_q.push_back(ref_buttons(pad_b));
      wait_valid(tgt + 1, 200);
      rand_pads(); pad_b[0] = 8'hFB;
      exp_q.push_back(ref_buttons(pad_b));
      @(posedge clk); #1;
      start_a = 1'b0;
      wait_valid(tgt + 2, 200);
      @(posedge clk); #1;
      held = 1'b0;

      // reset during the HIGH phase of bit 3 aborts the scan
      rand_pads();
      pulse_start();
      repeat (36) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_latch",    32'(latch_a), 32'd0);
      check("arst_ctrl_clk", 32'(cclk_a),  32'd0);
      check("arst_busy",     32'(busy_a),  32'd0);
      check("arst_buttons",  32'(btn_a),   32'd0);
      check("arst_valid",    32'(valid_a), 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      rand_pads();
      exp_q.push_back(ref_buttons(pad_b));
      tgt = valid_cnt + 1;
      pulse_start();
      wait_valid(tgt, 200);
      repeat (3) @(posedge clk);
      #1;

      // CLK_DIV=7 instance, data lines tied high
      ones = '{default: 8'hFF};
      lw = 0; r1 = -1; r2 = -1; vb = -1; bval = 0; pc = 1'b0;
      start_b = 1'b1;
      @(posedge clk); #1;
      start_b = 1'b0;
      for (int c = 0; c < 200 && vb < 0; c++) begin
         @(negedge clk);
         if (latch_b) lw++;
         if (cclk_b && !pc) begin
            if (r1 < 0) r1 = c;
            else if (r2 < 0) r2 = c;
         end
         pc = cclk_b;
         if (valid_b) begin vb = c; bval = 32'(btn_b); end
      end
      check("b_latch_width",     lw, 2*CD_B);
      check("b_ctrl_clk_period", r2 - r1, 2*CD_B);
      check("b_valid_latency",   vb, 18*CD_B);
      check("b_buttons",         bval, 32'(ref_buttons(ones)));

      repeat (5) @(posedge clk);
      #1;
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
